// File: rtl/svo_tpg.sv
`default_nettype none
// ============================================================================
//  Module   : svo_tpg
//  Purpose  : Multi-pattern raster test-pattern generator (AXI-Stream video).
//             Solid / colour bars / checkerboard / grey ramp, per-frame scroll.
//  Revision : 1.0 - initial release
// ============================================================================
module svo_tpg #(
  parameter int HOR_PIXELS = 640,
  parameter int VER_PIXELS = 480,
  parameter int BPC        = 8,
  parameter int CELL_LOG2  = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_scroll,
  input  logic [3*BPC-1:0]   cfg_color,
  output logic               out_axis_tvalid,
  input  logic               out_axis_tready,
  output logic [3*BPC-1:0]   out_axis_tdata,
  output logic               out_axis_tuser,
  output logic               out_axis_tlast,
  output logic [15:0]        frame_count
);

  localparam int XW   = $clog2(HOR_PIXELS);
  localparam int YW   = $clog2(VER_PIXELS);
  localparam int BARW = HOR_PIXELS / 8;

  localparam logic [XW-1:0]  c_x_last = XW'(HOR_PIXELS - 1);
  localparam logic [YW-1:0]  c_y_last = YW'(VER_PIXELS - 1);
  localparam logic [BPC-1:0] c_full   = {BPC{1'b1}};

  // cursors, scrolled column and per-frame shadow configuration
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [XW-1:0]    r_xs;
  logic [XW-1:0]    r_scroll;
  logic [1:0]       r_mode;
  logic             r_scroll_en;
  logic [3*BPC-1:0] r_color;
  logic             r_eof;

  logic             w_adv;
  logic             w_sof;
  logic             w_x_end;
  logic             w_y_end;
  logic [1:0]       w_mode;
  logic [3*BPC-1:0] w_color;
  logic             w_scroll_en;
  logic [XW-1:0]    w_scroll_nxt;
  logic [XW-1:0]    w_xs_inc;
  logic [6:0]       w_bar_ge;
  logic [2:0]       w_bar_idx;
  logic             w_xs_bit;
  logic             w_y_bit;
  logic             w_chk;
  logic [BPC-1:0]   w_r;
  logic [BPC-1:0]   w_g;
  logic [BPC-1:0]   w_b;

  assign w_adv   = !out_axis_tvalid || out_axis_tready;
  assign w_sof   = (r_x == '0) && (r_y == '0);
  assign w_x_end = (r_x == c_x_last);
  assign w_y_end = (r_y == c_y_last);

  // Pixel (0,0) uses the live config so a change on that very edge is captured.
  assign w_mode      = w_sof ? cfg_mode   : r_mode;
  assign w_color     = w_sof ? cfg_color  : r_color;
  assign w_scroll_en = w_sof ? cfg_scroll : r_scroll_en;

  assign w_scroll_nxt = !w_scroll_en ? r_scroll :
                        (r_scroll == c_x_last) ? '0 : r_scroll + XW'(1);
  assign w_xs_inc     = (r_xs == c_x_last) ? '0 : r_xs + XW'(1);

  // Bar index = number of bar boundaries passed; bar 7 absorbs the remainder.
  for (genvar k = 1; k < 8; k++) begin : g_bar
    assign w_bar_ge[k-1] = (r_xs >= XW'(k * BARW));
  end

  always_comb begin
    w_bar_idx = '0;
    for (int k = 0; k < 7; k++) begin
      w_bar_idx = w_bar_idx + {2'b00, w_bar_ge[k]};
    end
  end

  // A cell bit beyond the cursor width is constantly zero.
  if (CELL_LOG2 < XW) begin : g_xbit
    assign w_xs_bit = r_xs[CELL_LOG2];
  end else begin : g_xbit_zero
    assign w_xs_bit = 1'b0;
  end

  if (CELL_LOG2 < YW) begin : g_ybit
    assign w_y_bit = r_y[CELL_LOG2];
  end else begin : g_ybit_zero
    assign w_y_bit = 1'b0;
  end

  assign w_chk = w_xs_bit ^ w_y_bit;

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_mode)
      2'd0: {w_b, w_g, w_r} = w_color;
      2'd1: begin
        w_r = w_bar_idx[1] ? '0 : c_full;
        w_g = w_bar_idx[2] ? '0 : c_full;
        w_b = w_bar_idx[0] ? '0 : c_full;
      end
      2'd2: begin
        w_r = w_chk ? c_full : '0;
        w_g = w_chk ? c_full : '0;
        w_b = w_chk ? c_full : '0;
      end
      default: begin
        w_r = BPC'(r_xs);
        w_g = BPC'(r_xs);
        w_b = BPC'(r_xs);
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= 1'b0;
      out_axis_tlast  <= 1'b0;
      frame_count     <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_xs            <= '0;
      r_scroll        <= '0;
      r_mode          <= '0;
      r_scroll_en     <= 1'b0;
      r_color         <= '0;
      r_eof           <= 1'b0;
    end else begin
      if (out_axis_tvalid && out_axis_tready && r_eof) begin
        frame_count <= frame_count + 16'd1;
      end
      if (w_adv) begin
        out_axis_tvalid <= 1'b1;
        out_axis_tdata  <= {w_b, w_g, w_r};
        out_axis_tuser  <= w_sof;
        out_axis_tlast  <= w_x_end;
        r_eof           <= w_x_end && w_y_end;
        if (w_sof) begin
          r_mode      <= cfg_mode;
          r_scroll_en <= cfg_scroll;
          r_color     <= cfg_color;
        end
        if (w_x_end) begin
          r_x <= '0;
          if (w_y_end) begin
            r_y      <= '0;
            r_scroll <= w_scroll_nxt;
            r_xs     <= w_scroll_nxt;
          end else begin
            r_y  <= r_y + YW'(1);
            r_xs <= r_scroll;
          end
        end else begin
          r_x  <= r_x + XW'(1);
          r_xs <= w_xs_inc;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_svo_tpg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_svo_tpg
//  Purpose  : Self-checking bench for svo_tpg (small 20x8 raster).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_svo_tpg;

  localparam int HOR = 20;
  localparam int VER = 8;
  localparam int BPC = 4;
  localparam int CL  = 2;
  localparam int DW  = 3 * BPC;
  localparam int FRAME = HOR * VER;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic          cfg_scroll = 1'b0;
  logic [DW-1:0] cfg_color = '0;
  logic          tvalid;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic          tuser;
  logic          tlast;
  logic [15:0]   frame_count;

  int n_chk = 0;
  int n_fail = 0;
  bit stall_en = 1'b0;

  logic [DW-1:0] acc_data[$];
  bit            acc_user[$];
  bit            acc_last[$];
  logic [DW-1:0] ref_data[$];

  svo_tpg #(.HOR_PIXELS(HOR), .VER_PIXELS(VER), .BPC(BPC), .CELL_LOG2(CL)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_mode(cfg_mode), .cfg_scroll(cfg_scroll), .cfg_color(cfg_color),
    .out_axis_tvalid(tvalid), .out_axis_tready(tready), .out_axis_tdata(tdata),
    .out_axis_tuser(tuser), .out_axis_tlast(tlast), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixel straight from the pattern definitions.
  function automatic logic [DW-1:0] pix(input int mode, input logic [DW-1:0] color,
                                        input int xs, input int y);
    logic [BPC-1:0] f, r, g, b;
    int i;
    f = {BPC{1'b1}};
    case (mode)
      0: return color;
      1: begin
        i = xs / (HOR / 8);
        if (i > 7) i = 7;
        r = ((i & 2) != 0) ? '0 : f;
        g = ((i & 4) != 0) ? '0 : f;
        b = ((i & 1) != 0) ? '0 : f;
        return {b, g, r};
      end
      2: return ((((xs >> CL) ^ (y >> CL)) & 1) != 0) ? {DW{1'b1}} : '0;
      default: begin
        r = BPC'(xs % (1 << BPC));
        return {r, r, r};
      end
    endcase
  endfunction

  // Reference model: expected output register contents after each edge.
  int            m_x, m_y, m_scroll, m_fc;
  int            sh_mode;
  bit            sh_scroll;
  logic [DW-1:0] sh_color;
  bit            m_valid, m_user, m_last, m_eof;
  logic [DW-1:0] m_data;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("reset_tvalid", 32'(tvalid), 32'd0);
      chk("reset_frame_count", 32'(frame_count), 32'd0);
      m_x = 0; m_y = 0; m_scroll = 0; m_fc = 0;
      sh_mode = 0; sh_scroll = 0; sh_color = '0;
      m_valid = 0; m_user = 0; m_last = 0; m_eof = 0; m_data = '0;
    end else begin
      chk("tvalid", 32'(tvalid), 32'(m_valid));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      if (m_valid) begin
        chk("tdata", 32'(tdata), 32'(m_data));
        chk("tuser", 32'(tuser), 32'(m_user));
        chk("tlast", 32'(tlast), 32'(m_last));
      end
      if (tvalid && tready) begin
        acc_data.push_back(tdata);
        acc_user.push_back(tuser);
        acc_last.push_back(tlast);
      end
      if (m_valid && tready && m_eof) m_fc = (m_fc + 1) % 65536;
      if (!m_valid || tready) begin
        if (m_x == 0 && m_y == 0) begin
          sh_mode = int'(cfg_mode); sh_scroll = cfg_scroll; sh_color = cfg_color;
        end
        m_data  = pix(sh_mode, sh_color, (m_x + m_scroll) % HOR, m_y);
        m_user  = (m_x == 0 && m_y == 0);
        m_last  = (m_x == HOR - 1);
        m_eof   = m_last && (m_y == VER - 1);
        m_valid = 1;
        m_x++;
        if (m_x == HOR) begin
          m_x = 0;
          m_y++;
          if (m_y == VER) begin
            m_y = 0;
            if (sh_scroll) m_scroll = (m_scroll + 1) % HOR;
          end
        end
      end
    end
  end

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (acc_data.size() < n && cyc < 4 * n + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (stall_en) tready = ($urandom_range(0, 99) >= 40);
    end
    if (acc_data.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_beats: actual %0d beats, required %0d", acc_data.size(), n);
    end
  endtask

  task automatic do_reset(input logic [1:0] mode, input bit scroll, input logic [DW-1:0] color);
    resetn = 1'b0;
    cfg_mode = mode; cfg_scroll = scroll; cfg_color = color;
    repeat (2) @(posedge clk);
    #1;
    acc_data.delete(); acc_user.delete(); acc_last.delete();
    resetn = 1'b1;
  endtask

  initial begin
    int users, diffs;
    tready = 1'b1;

    // Colour bars, no stall
    do_reset(2'd1, 1'b0, '0);
    wait_beats(FRAME + 1);
    chk("bars_first_data", 32'(acc_data[0]), 32'h0FFF);
    chk("bars_first_user", 32'(acc_user[0]), 32'd1);
    chk("bars_yellow", 32'(acc_data[2]), 32'h00FF);
    chk("bars_blue", 32'(acc_data[13]), 32'h0F00);
    chk("bars_remainder_black", 32'(acc_data[14]), 32'h0000);
    chk("bars_last_data", 32'(acc_data[19]), 32'h0000);
    chk("bars_last_tlast", 32'(acc_last[19]), 32'd1);
    chk("bars_x18_tlast", 32'(acc_last[18]), 32'd0);
    chk("bars_next_sof", 32'(acc_user[FRAME]), 32'd1);
    users = 0;
    for (int i = 0; i < FRAME; i++) users += int'(acc_user[i]);
    chk("tuser_once_per_frame", 32'(users), 32'd1);
    chk("frame_count_one", 32'(frame_count), 32'd1);
    ref_data = acc_data;

    // Checkerboard
    do_reset(2'd2, 1'b0, '0);
    wait_beats(FRAME + 1);
    chk("chk_0_0", 32'(acc_data[0]), 32'h000);
    chk("chk_4_0", 32'(acc_data[4]), 32'hFFF);
    chk("chk_4_4", 32'(acc_data[4 * HOR + 4]), 32'h000);
    chk("chk_0_4", 32'(acc_data[4 * HOR]), 32'hFFF);
    chk("chk_sof_recur", 32'(acc_user[FRAME]), 32'd1);

    // Grey ramp with scrolling over three frames
    do_reset(2'd3, 1'b1, '0);
    wait_beats(3 * FRAME + 1);
    chk("ramp_f0_first", 32'(acc_data[0]), 32'h000);
    chk("ramp_f0_x19", 32'(acc_data[19]), 32'h333);
    chk("ramp_f1_first", 32'(acc_data[FRAME]), 32'h111);
    chk("ramp_f1_x1", 32'(acc_data[FRAME + 1]), 32'h222);
    chk("ramp_f2_first", 32'(acc_data[2 * FRAME]), 32'h222);
    chk("ramp_frames", 32'(frame_count), 32'd3);

    // Random 40% stall: accepted stream must match the no-stall run
    stall_en = 1'b1;
    do_reset(2'd1, 1'b0, '0);
    wait_beats(FRAME + 1);
    stall_en = 1'b0;
    tready = 1'b1;
    diffs = 0;
    for (int i = 0; i <= FRAME; i++) if (acc_data[i] !== ref_data[i]) diffs++;
    chk("stall_sequence_diffs", 32'(diffs), 32'd0);

    // Mode switch mid-frame takes effect at the next frame
    do_reset(2'd0, 1'b0, 12'h5A3);
    wait_beats(70);
    cfg_mode = 2'd1;
    wait_beats(FRAME + 3);
    chk("switch_mid_solid", 32'(acc_data[100]), 32'h5A3);
    chk("switch_end_solid", 32'(acc_data[FRAME - 1]), 32'h5A3);
    chk("switch_next_bars", 32'(acc_data[FRAME]), 32'hFFF);
    chk("switch_next_yellow", 32'(acc_data[FRAME + 2]), 32'h0FF);

    // Mid-line asynchronous reset
    do_reset(2'd3, 1'b1, '0);
    wait_beats(FRAME + 10);
    resetn = 1'b0;
    #1;
    chk("async_tvalid", 32'(tvalid), 32'd0);
    chk("async_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk); #1;
    acc_data.delete(); acc_user.delete(); acc_last.delete();
    resetn = 1'b1;
    wait_beats(2);
    chk("restart_data", 32'(acc_data[0]), 32'h000);
    chk("restart_user", 32'(acc_user[0]), 32'd1);
    chk("restart_x1", 32'(acc_data[1]), 32'h111);
    chk("restart_frame_count", 32'(frame_count), 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
